hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_CYCLES, default 8, giving the multi-cycle MDU latency in cycles; legal values are 2..256.
REQ-002 The block SHALL have parameter REG_BITS, default 5, giving the register-index width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Rs1D, Rs2D  in  REG_BITS  decode-stage source registers.
REQ-006 Rs1E, Rs2E, RdE  in  REG_BITS  execute-stage source and destination registers.
REQ-007 RdM, RdW  in  REG_BITS  memory- and writeback-stage destination registers.
REQ-008 RegWriteM, RegWriteW  in  1  register-write valid in M and W.
REQ-009 LoadE  in  1  EX instruction is a load.
REQ-010 PCSrcE  in  1  taken branch or jump resolved in EX.
REQ-011 MdStartE  in  1  EX instruction is a multi-cycle MDU operation.
REQ-012 ForwardAE, ForwardBE  out  2  operand mux selects: 00 = register file, 01 = W result, 10 = M result.
REQ-013 StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX enable-flops.
REQ-014 FlushD, FlushE, FlushM  out  1  clear the IF/ID, ID/EX and EX/M registers.
REQ-015 MdBusy, MdDone  out  1  registered MDU sequencing status.

Function
REQ-016 ForwardAE SHALL be 10 when RegWriteM, RdM!=0 and Rs1E==RdM; otherwise 01 when RegWriteW, RdW!=0 and Rs1E==RdW; otherwise 00. ForwardBE SHALL use the same rule with Rs2E. The M stage has priority.
REQ-017 lwStall SHALL be LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE); this term is combinational.
REQ-018 The MDU FSM SHALL have the states IDLE, BUSY and DONE, with a down-counter of width clog2(MDU_CYCLES).
REQ-019 IDLE->BUSY SHALL occur when MdStartE=1 and PCSrcE=0; the counter loads MDU_CYCLES-2.
REQ-020 In BUSY, the counter SHALL decrement each cycle; at count 0 the FSM moves BUSY->DONE.
REQ-021 DONE->IDLE SHALL occur unconditionally after one cycle; MdStartE is ignored in DONE because it belongs to the finishing instruction.
REQ-022 MdBusy SHALL be 1 exactly in BUSY and MdDone SHALL be 1 exactly in DONE, so total EX occupancy is MDU_CYCLES cycles.
REQ-023 While in BUSY, or in IDLE with MdStartE=1, the block SHALL drive StallF=StallD=StallE=1, FlushM=1 and FlushE=0.
REQ-024 Outside the REQ-023 condition, the block SHALL drive StallF=StallD=lwStall, StallE=0 and FlushM=0.
REQ-025 Outside the REQ-023 condition, FlushD SHALL equal PCSrcE and FlushE SHALL equal lwStall|PCSrcE.
REQ-026 The REQ-023 stall condition SHALL override lwStall and PCSrcE when they occur simultaneously.

Reset
REQ-027 While reset=1, the FSM SHALL go to IDLE, the counter to 0, and MdBusy/MdDone to 0 on the next edge.
REQ-028 While reset=1, all Stall outputs SHALL be 0, FlushD=FlushE=FlushM=1, and ForwardAE/BE=00.
REQ-029 A reset asserted in BUSY or DONE SHALL abort the MDU sequence; the first cycle after reset deasserts is IDLE.

Configuration
REQ-030 The macro HAZARD_CTRL_MDU_EN SHALL control the MDU feature.
- Defined: REQ-018..REQ-023 are active.
- Undefined: the FSM and counter are absent; MdStartE is ignored; MdBusy=MdDone=StallE=FlushM=0 constantly, except FlushM=1 under reset; port list is unchanged.

Verification
REQ-031 Rs1E=3, RdM=3, RegWriteM=1, RdW=3, RegWriteW=1 -> ForwardAE=10; repeat with RdM=0 -> ForwardAE=01.
REQ-032 LoadE=1, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 for one cycle; with RdE=0 -> no stall.
REQ-033 PCSrcE=1 with no MDU -> FlushD=FlushE=1, stalls 0.
REQ-034 MDU_CYCLES=8, single-cycle MdStartE pulse held in EX:
- StallE=1 for 7 cycles;
- MdBusy=1 for 6 cycles, then MdDone=1 for 1 cycle;
- IDLE on the following cycle.
REQ-035 Reset asserted at BUSY count 3 -> next cycle IDLE, MdBusy=0, all Flush outputs=1 during reset.
REQ-036 HAZARD_CTRL_MDU_EN undefined, MdStartE=1 -> MdBusy=0, StallE=0, pipeline not stalled.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: register indices and control in, forwarding/stall/flush out.
interface hazard_ctrl_if #(parameter int REG_BITS = 5);
  logic [REG_BITS-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;
  logic [1:0]          ForwardAE, ForwardBE;
  logic                StallF, StallD, StallE;
  logic                FlushD, FlushE, FlushM;
  logic                MdBusy, MdDone;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MdBusy, MdDone
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MdBusy, MdDone
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and optional multi-cycle MDU hold.
// The MDU sequencer is built only when HAZARD_CTRL_MDU_EN is defined.
module hazard_ctrl #(
  parameter int MDU_CYCLES = 8,
  parameter int REG_BITS   = 5
) (
  input  logic     clk,
  input  logic     reset,
  hazard_ctrl_if.slave hz
);

  logic lw_stall, md_hold;

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs,
                                         input logic [REG_BITS-1:0] rd_m, input logic we_m,
                                         input logic [REG_BITS-1:0] rd_w, input logic we_w);
    if (we_m && rd_m != '0 && rs == rd_m)      return 2'b10;
    else if (we_w && rd_w != '0 && rs == rd_w) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign lw_stall = hz.LoadE && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

`ifdef HAZARD_CTRL_MDU_EN
  localparam int CW = $clog2(MDU_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The decrement that lands on 0 is the exit, so IDLE start + BUSY + DONE spans MDU_CYCLES.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (hz.MdStartE && !hz.PCSrcE) begin
        state_n = (MDU_CYCLES == 2) ? DONE : BUSY;
        cnt_n   = CW'(MDU_CYCLES - 2);
      end
      BUSY: if (cnt <= CW'(1)) begin
        state_n = DONE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt - 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign md_hold   = (state == BUSY) || (state == IDLE && hz.MdStartE);
  assign hz.MdBusy = (state == BUSY);
  assign hz.MdDone = (state == DONE);
`else
  wire unused_md = ^{clk, hz.MdStartE};

  assign md_hold   = 1'b0;
  assign hz.MdBusy = 1'b0;
  assign hz.MdDone = 1'b0;
`endif

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    if (reset) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
    end else begin
      hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      // An MDU hold freezes F/D/E and bubbles M; it wins over load-use and branch.
      if (md_hold) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else begin
        hz.StallF = lw_stall;
        hz.StallD = lw_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall || hz.PCSrcE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle queues its expected output vector, checked at negedge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_BITS(5)) hz ();

  hazard_ctrl #(.MDU_CYCLES(8), .REG_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, load, pcsrc, mdstart;
  } stim_t;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, want);
    end
  endtask

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone}
  function automatic logic [11:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic b, input logic d);
    return {fa, fb, sf, sd, se, fd, fe, fm, b, d};
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0,
          rdm: 5'd0, rdw: 5'd0, rwm: 1'b0, rww: 1'b0, load: 1'b0, pcsrc: 1'b0, mdstart: 1'b0};
    return s;
  endfunction

  task automatic step(input stim_t s, input string tag, input logic [11:0] e, input bit do_chk);
    exp_t it;
    @(posedge clk);
    #1;
    reset        = s.rst;
    hz.Rs1D      = s.rs1d;  hz.Rs2D = s.rs2d;
    hz.Rs1E      = s.rs1e;  hz.Rs2E = s.rs2e;  hz.RdE = s.rde;
    hz.RdM       = s.rdm;   hz.RdW  = s.rdw;
    hz.RegWriteM = s.rwm;   hz.RegWriteW = s.rww;
    hz.LoadE     = s.load;  hz.PCSrcE = s.pcsrc;  hz.MdStartE = s.mdstart;
    if (do_chk) begin
      it.tag = tag;
      it.val = e;
      exp_q.push_back(it);
    end
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      chk(it.tag, {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
                   hz.FlushD, hz.FlushE, hz.FlushM, hz.MdBusy, hz.MdDone}, it.val);
    end
  end

  localparam logic [11:0] RST_V  = 12'b00_00_000_111_00;
  localparam logic [11:0] ZERO_V = 12'b0;

  initial begin
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    step(s, "rst0", RST_V, 1'b0);
    step(s, "reset", RST_V, 1'b1);
    s.rs1e = 5'd3; s.rdm = 5'd3; s.rwm = 1'b1;
    step(s, "reset_fwd", RST_V, 1'b1);

    s = idle_s();
    step(s, "idle", ZERO_V, 1'b1);

    // forwarding priority and x0 handling
    s = idle_s(); s.rs1e = 5'd3; s.rdm = 5'd3; s.rwm = 1'b1; s.rdw = 5'd3; s.rww = 1'b1;
    step(s, "fwdA_m", ex(2'b10, 2'b00, 0,0,0, 0,0,0, 0,0), 1'b1);
    s.rdm = 5'd0;
    step(s, "fwdA_w", ex(2'b01, 2'b00, 0,0,0, 0,0,0, 0,0), 1'b1);
    s = idle_s(); s.rs2e = 5'd7; s.rdm = 5'd7; s.rwm = 1'b0; s.rdw = 5'd7; s.rww = 1'b1;
    step(s, "fwdB_w", ex(2'b00, 2'b01, 0,0,0, 0,0,0, 0,0), 1'b1);
    s.rwm = 1'b1; s.rs1e = 5'd9; s.rdw = 5'd9;
    step(s, "fwdAB", ex(2'b01, 2'b10, 0,0,0, 0,0,0, 0,0), 1'b1);
    s = idle_s(); s.rs1e = 5'd0; s.rdw = 5'd0; s.rww = 1'b1; s.rs2e = 5'd0; s.rdm = 5'd0; s.rwm = 1'b1;
    step(s, "fwd_x0", ZERO_V, 1'b1);

    // load-use
    s = idle_s(); s.load = 1'b1; s.rde = 5'd5; s.rs2d = 5'd5;
    step(s, "lw_rs2", ex(2'b00, 2'b00, 1,1,0, 0,1,0, 0,0), 1'b1);
    s = idle_s();
    step(s, "lw_clear", ZERO_V, 1'b1);
    s = idle_s(); s.load = 1'b1; s.rde = 5'd0; s.rs1d = 5'd0;
    step(s, "lw_x0", ZERO_V, 1'b1);
    s = idle_s(); s.load = 1'b1; s.rde = 5'd12; s.rs1d = 5'd12;
    step(s, "lw_rs1", ex(2'b00, 2'b00, 1,1,0, 0,1,0, 0,0), 1'b1);
    s = idle_s(); s.rs1d = 5'd4; s.rde = 5'd4;
    step(s, "noload", ZERO_V, 1'b1);

    // branch
    s = idle_s(); s.pcsrc = 1'b1;
    step(s, "branch", ex(2'b00, 2'b00, 0,0,0, 1,1,0, 0,0), 1'b1);
    s.load = 1'b1; s.rde = 5'd6; s.rs1d = 5'd6;
    step(s, "br_lw", ex(2'b00, 2'b00, 1,1,0, 1,1,0, 0,0), 1'b1);

`ifdef HAZARD_CTRL_MDU_EN
    // MDU held in EX for MDU_CYCLES=8: 1 start + 6 busy + 1 done
    for (int k = 0; k < 8; k++) begin
      s = idle_s(); s.mdstart = 1'b1;
      if (k == 3) begin s.pcsrc = 1'b1; s.load = 1'b1; s.rde = 5'd2; s.rs1d = 5'd2; end
      if (k < 7) step(s, $sformatf("mdu_c%0d", k), ex(2'b00, 2'b00, 1,1,1, 0,0,1, (k > 0), 0), 1'b1);
      else       step(s, "mdu_done", ex(2'b00, 2'b00, 0,0,0, 0,0,0, 0,1), 1'b1);
    end
    s = idle_s();
    step(s, "mdu_idle", ZERO_V, 1'b1);
    step(s, "mdu_idle2", ZERO_V, 1'b1);

    // reset aborts BUSY at count 3
    for (int k = 0; k < 4; k++) begin
      s = idle_s(); s.mdstart = 1'b1;
      step(s, $sformatf("abort_c%0d", k), ex(2'b00, 2'b00, 1,1,1, 0,0,1, (k > 0), 0), 1'b1);
    end
    s = idle_s(); s.rst = 1'b1; s.mdstart = 1'b1;
    step(s, "abort_rst", ex(2'b00, 2'b00, 0,0,0, 1,1,1, 1,0), 1'b1);
    s = idle_s();
    step(s, "abort_idle", ZERO_V, 1'b1);
    step(s, "abort_idle2", ZERO_V, 1'b1);
`else
    // MDU absent: MdStartE has no effect
    s = idle_s(); s.mdstart = 1'b1;
    for (int k = 0; k < 3; k++) step(s, $sformatf("nomdu_%0d", k), ZERO_V, 1'b1);
    s.load = 1'b1; s.rde = 5'd8; s.rs2d = 5'd8;
    step(s, "nomdu_lw", ex(2'b00, 2'b00, 1,1,0, 0,1,0, 0,0), 1'b1);
    s = idle_s(); s.mdstart = 1'b1; s.rst = 1'b1;
    step(s, "nomdu_rst", RST_V, 1'b1);
    s = idle_s(); s.mdstart = 1'b1; s.pcsrc = 1'b1;
    step(s, "nomdu_br", ex(2'b00, 2'b00, 0,0,0, 1,1,0, 0,0), 1'b1);
`endif

    s = idle_s();
    step(s, "tail", ZERO_V, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) chk("drain", 12'(exp_q.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
